// File: rtl/debouncer_pkg.sv
// Shared constants and width helpers for the debouncer channel and array.
package debouncer_pkg;

    // Released pin level for pull-up style buttons.
    localparam logic IDLE_LEVEL_DEFAULT = 1'b1;

    // Bits needed to hold the values 0..max_count inclusive.
    function automatic int unsigned count_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/debouncer_ch.sv
// One debounced channel: synchroniser, stability filter, press/release
// edge pulses and long-press detection.
module debouncer_ch
    import debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 10,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned LONG_CYCLES   = 100,
    parameter logic        IDLE_LEVEL    = IDLE_LEVEL_DEFAULT
) (
    input  logic clk,
    input  logic RSTn,
    input  logic button_in,
    output logic button_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic held_long
);

    localparam int unsigned CW = count_width(STABLE_CYCLES);
    localparam int unsigned HW = count_width(LONG_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic [HW-1:0]          hold;
    logic                   sync_out;
    logic                   flip;
    logic                   active;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign flip     = (sync_out != button_out) && (cnt == CNT_LAST);
    assign active   = (button_out != IDLE_LEVEL);

    // Metastability chain; reset to the released level so release is silent.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
        end
    end

    // Stability filter: output follows only after an unbroken mismatch run.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            cnt           <= '0;
            button_out    <= IDLE_LEVEL;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (flip) begin
                button_out    <= sync_out;
                cnt           <= '0;
                press_pulse   <= (sync_out != IDLE_LEVEL);
                release_pulse <= (sync_out == IDLE_LEVEL);
            end else if (sync_out != button_out) begin
                cnt <= cnt + CW'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Hold timer: counts active cycles from the press cycle, saturates at the
    // long-press threshold and clears on the release edge.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            hold       <= '0;
            long_pulse <= 1'b0;
            held_long  <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (flip) begin
                hold      <= '0;
                held_long <= 1'b0;
            end else if (active && (hold != HOLD_MAX)) begin
                hold <= hold + HW'(1);
                if (hold == HOLD_LAST) begin
                    long_pulse <= 1'b1;
                    held_long  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debouncer_array.sv
// N_CH independent debounced button channels sharing one clock and reset.
module debouncer_array
    import debouncer_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 10,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned LONG_CYCLES   = 100,
    parameter logic        IDLE_LEVEL    = IDLE_LEVEL_DEFAULT
) (
    input  logic            clk,
    input  logic            RSTn,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] button_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] held_long
);

    // One fully independent filter per channel; no shared state.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debouncer_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .LONG_CYCLES   (LONG_CYCLES),
            .IDLE_LEVEL    (IDLE_LEVEL)
        ) u_ch (
            .clk           (clk),
            .RSTn          (RSTn),
            .button_in     (button_in[i]),
            .button_out    (button_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .held_long     (held_long[i])
        );
    end

endmodule

// File: tb/tb_debouncer_array.sv
// Directed bench for debouncer_array: vector table plus multi-cycle sequences.
`timescale 1ns/1ns
module tb_debouncer_array;

    logic       clk = 1'b0;
    logic       RSTn = 1'b1;
    logic [3:0] button_in = 4'b1111;
    logic [3:0] button_out, press_pulse, release_pulse, long_pulse, held_long;

    int total = 0;
    int bad   = 0;

    debouncer_array #(
        .N_CH          (4),
        .STABLE_CYCLES (10),
        .SYNC_STAGES   (2),
        .LONG_CYCLES   (50),
        .IDLE_LEVEL    (1'b1)
    ) dut (
        .clk           (clk),
        .RSTn          (RSTn),
        .button_in     (button_in),
        .button_out    (button_out),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .held_long     (held_long)
    );

    // 10 us period
    always #5000 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        int         cyc;
        logic [3:0] out;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
        logic [3:0] hld;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Steps n edges, recording pulse counts and the first edge each appears on.
    task automatic step_count(input int n, input int ch,
                              output int np, output int nr, output int nl,
                              output int fp, output int fr, output int fl);
        np = 0; nr = 0; nl = 0; fp = 0; fr = 0; fl = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (press_pulse[ch])   begin np++; if (fp == 0) fp = k; end
            if (release_pulse[ch]) begin nr++; if (fr == 0) fr = k; end
            if (long_pulse[ch])    begin nl++; if (fl == 0) fl = k; end
        end
    endtask

    initial begin
        int np, nr, nl, fp, fr, fl, stray;

        // btn, cycles, out, press, release, long, held
        vecs[0]  = '{4'b1111,  1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b1110, 11, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b1110,  1, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        vecs[3]  = '{4'b1110,  1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b1111, 11, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b1111,  1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vecs[6]  = '{4'b1111,  1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b0110, 11, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b0110,  1, 4'b0110, 4'b1001, 4'b0000, 4'b0000, 4'b0000};
        vecs[9]  = '{4'b0110,  1, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[10] = '{4'b1111, 12, 4'b1111, 4'b0000, 4'b1001, 4'b0000, 4'b0000};
        vecs[11] = '{4'b1111,  1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        // Reset with all inputs pressed: outputs forced idle.
        button_in = 4'b0000;
        #1 RSTn = 1'b0;
        #1;
        check("async_reset_out", button_out, 4'b1111);
        step(4);
        check("reset_out", button_out, 4'b1111);
        check("reset_pulses", press_pulse | release_pulse | long_pulse, 4'b0000);
        check("reset_held", held_long, 4'b0000);
        button_in = 4'b1111;
        RSTn = 1'b1;
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if ((press_pulse | release_pulse | long_pulse | held_long) != 4'b0000)
                stray++;
            if (button_out != 4'b1111) stray++;
        end
        check("post_reset_quiet", stray, 0);

        // Clean press/release on ch0, then simultaneous ch0+ch3.
        for (int v = 0; v < 12; v++) begin
            button_in = vecs[v].btn;
            step(vecs[v].cyc);
            check($sformatf("vec%0d_out", v), button_out, vecs[v].out);
            check($sformatf("vec%0d_press", v), press_pulse, vecs[v].prs);
            check($sformatf("vec%0d_release", v), release_pulse, vecs[v].rel);
            check($sformatf("vec%0d_long", v), long_pulse, vecs[v].lng);
            check($sformatf("vec%0d_held", v), held_long, vecs[v].hld);
        end

        // Bounce on ch1: no event until the final low run has been stable.
        stray = 0;
        button_in[1] = 1'b0; step_count(5, 1, np, nr, nl, fp, fr, fl); stray += np + nr;
        button_in[1] = 1'b1; step_count(2, 1, np, nr, nl, fp, fr, fl); stray += np + nr;
        button_in[1] = 1'b0; step_count(3, 1, np, nr, nl, fp, fr, fl); stray += np + nr;
        button_in[1] = 1'b1; step_count(1, 1, np, nr, nl, fp, fr, fl); stray += np + nr;
        check("bounce_no_pulse", stray, 0);
        check("bounce_out_high", button_out, 4'b1111);
        button_in[1] = 1'b0;
        step_count(12, 1, np, nr, nl, fp, fr, fl);
        check("bounce_press_edge", fp, 12);
        check("bounce_press_count", np, 1);
        check("bounce_out_low", button_out, 4'b1101);
        button_in[1] = 1'b1;
        step_count(13, 1, np, nr, nl, fp, fr, fl);
        check("bounce_release_edge", fr, 12);

        // Long press on ch2: 80 cycles held.
        button_in[2] = 1'b0;
        step_count(80, 2, np, nr, nl, fp, fr, fl);
        check("long_press_edge", fp, 12);
        check("long_pulse_edge", fl, 62);
        check("long_pulse_count", nl, 1);
        check("long_held_level", held_long, 4'b0100);
        button_in[2] = 1'b1;
        step(11);
        check("long_held_before_rel", held_long, 4'b0100);
        check("long_out_before_rel", button_out, 4'b1011);
        step(1);
        check("long_release_pulse", release_pulse, 4'b0100);
        check("long_held_cleared", held_long, 4'b0000);
        check("long_out_released", button_out, 4'b1111);

        // Short hold on ch2 (30 cycles) must not flag a long press.
        button_in[2] = 1'b0;
        step_count(30, 2, np, nr, nl, fp, fr, fl);
        stray = nl;
        check("short_press_count", np, 1);
        button_in[2] = 1'b1;
        step_count(20, 2, np, nr, nl, fp, fr, fl);
        stray += nl;
        check("short_no_long", stray, 0);
        check("short_release_edge", fr, 12);

        // Reset mid-count on ch0 while ch3 is already pressed.
        button_in[3] = 1'b0;
        step(13);
        check("pre_reset_ch3_low", button_out, 4'b0111);
        button_in[0] = 1'b0;
        step(9);
        RSTn = 1'b0;
        #1;
        check("midreset_async_out", button_out, 4'b1111);
        step(1);
        RSTn = 1'b1;
        step(11);
        check("midreset_edge11_out", button_out, 4'b1111);
        step(1);
        check("midreset_edge12_out", button_out, 4'b0110);
        check("midreset_edge12_press", press_pulse, 4'b1001);

        button_in = 4'b1111;
        step(13);
        check("final_idle", button_out, 4'b1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
